rejection_sampler: RTL

- Upstream driver for the combinational constraint-checker block.
- Generates pseudo-random candidate assignments for var_0..var_4 from an LFSR and presents them to the checker.
- Reads the checker's constraint_0..7 results back and forwards only accepted candidates downstream on a valid/ready stream.
- Produces a requested number of samples per start command, with a per-sample try limit.

---
 rtl/sampler_pkg.sv | 32 +++
 rtl/lfsr_galois32.sv | 26 ++
 rtl/rejection_sampler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the rejection sampler and its LFSR.
// Holds the FSM state enum, LFSR mask, candidate widths and slice offsets.
package sampler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_CHECK,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam int VAR0_W   = 2;
  localparam int VAR1_W   = 3;
  localparam int VAR2_W   = 4;
  localparam int VAR3_W   = 5;
  localparam int VAR4_W   = 6;
  localparam int SAMPLE_W = 20;

  localparam int VAR0_LO = 0;
  localparam int VAR1_LO = 2;
  localparam int VAR2_LO = 5;
  localparam int VAR3_LO = 9;
  localparam int VAR4_LO = 14;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr_galois32.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step.
// Ports: clk, rst, load, load_val[31:0], step -> state[31:0].
module lfsr_galois32
  import sampler_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/rejection_sampler.sv
// Drives LFSR candidates to a combinational checker; streams accepted ones.
// Ports: start/seed/num_samples in, cand_var_* out, constraint_in in, out_* stream, status.
module rejection_sampler
  import sampler_pkg::*;
#(
  parameter logic [7:0]  CONSTRAINT_MASK = 8'hFF,
  parameter int          MAX_TRIES       = 1024,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] SEED_DEFAULT    = 32'hACE1_2468
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         seed,
  input  logic [CNT_W-1:0]    num_samples,
  output logic [VAR0_W-1:0]   cand_var_0,
  output logic [VAR1_W-1:0]   cand_var_1,
  output logic [VAR2_W-1:0]   cand_var_2,
  output logic [VAR3_W-1:0]   cand_var_3,
  output logic [VAR4_W-1:0]   cand_var_4,
  input  logic [7:0]          constraint_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_var,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    tries
);

  localparam logic [CNT_W-1:0] TRY_LAST = CNT_W'(MAX_TRIES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_n;
  logic [CNT_W-1:0] remaining;
  logic             start_ok;
  logic             pass;
  logic             try_last;
  logic             rem_last;

  assign start_ok = (state == S_IDLE) && start;
  assign pass     = (constraint_in & CONSTRAINT_MASK) == CONSTRAINT_MASK;
  assign try_last = tries == TRY_LAST;
  // The handshake consumes the last outstanding sample.
  assign rem_last = remaining == ONE;
  // Candidate is cut from the value the LFSR steps to this cycle.
  assign lfsr_n   = lfsr_next(lfsr_q);

  assign busy = state != S_IDLE;
  assign done = state == S_DONE;

  lfsr_galois32 #(
    .RESET_VAL(SEED_DEFAULT)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .load_val((seed == 32'h0) ? SEED_DEFAULT : seed),
    .step    (state == S_GEN),
    .state   (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_samples == '0) ? S_DONE : S_GEN;
        end
      end
      S_GEN: state_nxt = S_CHECK;
      S_CHECK: begin
        if (pass) begin
          state_nxt = S_HOLD;
        end else if (try_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_GEN;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_nxt = rem_last ? S_DONE : S_GEN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_var_0 <= '0;
      cand_var_1 <= '0;
      cand_var_2 <= '0;
      cand_var_3 <= '0;
      cand_var_4 <= '0;
      out_valid  <= 1'b0;
      out_var    <= '0;
      err        <= 1'b0;
      tries      <= '0;
      remaining  <= '0;
    end else begin
      if (start_ok) begin
        remaining <= num_samples;
        err       <= 1'b0;
        tries     <= '0;
      end
      if (state == S_GEN) begin
        cand_var_0 <= lfsr_n[VAR0_LO +: VAR0_W];
        cand_var_1 <= lfsr_n[VAR1_LO +: VAR1_W];
        cand_var_2 <= lfsr_n[VAR2_LO +: VAR2_W];
        cand_var_3 <= lfsr_n[VAR3_LO +: VAR3_W];
        cand_var_4 <= lfsr_n[VAR4_LO +: VAR4_W];
      end
      if (state == S_CHECK) begin
        if (pass) begin
          out_var   <= {cand_var_4, cand_var_3, cand_var_2,
                        cand_var_1, cand_var_0};
          out_valid <= 1'b1;
          tries     <= '0;
        end else if (try_last) begin
          err <= 1'b1;
        end else begin
          tries <= tries + ONE;
        end
      end
      if ((state == S_HOLD) && out_ready) begin
        out_valid <= 1'b0;
        remaining <= remaining - ONE;
      end
    end
  end

endmodule
